// File: rtl/axis_uart_if.sv
// AXI-Stream byte channel used on both sides of axis_uart.
// master drives tdata/tvalid, slave drives tready; a beat moves on tvalid && tready.
interface axis_uart_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart.sv
// Full-duplex 8N1 UART with AXI-Stream byte ports; one bit = prescale*8 clk cycles (0 acts as 1).
// TX stalls tready for a whole frame; RX holds one byte and overwrites it (overrun pulse) if unread.
module axis_uart #(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  axis_uart_if.slave  input_axis,
  axis_uart_if.master output_axis,
  input  logic        rxd,
  output logic        txd,
  output logic        tx_busy,
  output logic        rx_busy,
  output logic        rx_overrun_error,
  output logic        rx_frame_error,
  input  logic [15:0] prescale
);

  localparam int CW = 19;
  localparam int BW = $clog2(DATA_WIDTH + 2);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Reload values are recomputed from the live prescale at every boundary,
  // so a change only takes effect from the next bit onwards.
  logic [15:0]   ps_eff;
  logic [CW-1:0] bit_reload;
  logic [CW-1:0] half_reload;

  always_comb begin
    ps_eff      = (prescale == 16'd0) ? 16'd1 : prescale;
    bit_reload  = {ps_eff, 3'b000} - CW'(1);
    half_reload = {1'b0, ps_eff, 2'b00} - CW'(1);
  end

  // ------------------------------------------------------------------ TX
  tx_state_e           tx_state_q, tx_state_d;
  logic [CW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [DATA_WIDTH:0] tx_shift_q, tx_shift_d;
  logic [BW-1:0]       tx_bits_q, tx_bits_d;
  logic                txd_q, txd_d;
  logic                tready_q, tready_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bits_q  <= '0;
      txd_q      <= 1'b1;
      tready_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bits_q  <= tx_bits_d;
      txd_q      <= txd_d;
      tready_q   <= tready_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bits_d  = tx_bits_q;
    txd_d      = txd_q;
    tready_d   = tready_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tready_d = 1'b1;
        txd_d    = 1'b1;
        if (input_axis.tvalid && tready_q) begin
          tready_d   = 1'b0;
          txd_d      = 1'b0;
          tx_shift_d = {1'b1, input_axis.tdata};
          tx_bits_d  = BW'(DATA_WIDTH + 1);
          tx_cnt_d   = bit_reload;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cnt_q == '0) begin
          // tx_bits_q counts the data+stop bits still to be put on the line.
          if (tx_bits_q == '0) begin
            tx_state_d = TX_IDLE;
            tready_d   = 1'b1;
            txd_d      = 1'b1;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bits_d  = tx_bits_q - BW'(1);
            tx_cnt_d   = bit_reload;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign txd              = txd_q;
  assign tx_busy          = (tx_state_q == TX_SEND);
  assign input_axis.tready = tready_q;

  // ------------------------------------------------------------------ RX
  logic [1:0]            sync_q;
  logic                  rxd_s;
  rx_state_e             rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [BW-1:0]         rx_bits_q, rx_bits_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  out_vld_q, out_vld_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bits_q  <= '0;
      out_dat_q  <= '0;
      out_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rxd};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bits_q  <= rx_bits_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_bits_d  = rx_bits_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    ovr_d      = 1'b0;
    ferr_d     = 1'b0;
    if (out_vld_q && output_axis.tready) begin
      out_vld_d = 1'b0;
    end
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxd_s) begin
          rx_cnt_d   = half_reload;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rxd_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = bit_reload;
            rx_bits_d  = '0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxd_s, rx_shift_q[DATA_WIDTH-1:1]};
          rx_cnt_d   = bit_reload;
          if (rx_bits_q == BW'(DATA_WIDTH - 1)) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bits_d = rx_bits_q + BW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rxd_s) begin
            // A landing byte beats a same-cycle read, so only an unread byte counts as overrun.
            out_dat_d  = rx_shift_q;
            out_vld_d  = 1'b1;
            ovr_d      = out_vld_q && !output_axis.tready;
            rx_state_d = RX_IDLE;
          end else begin
            ferr_d     = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxd_s) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_busy            = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                              (rx_state_q == RX_STOP);
  assign rx_overrun_error   = ovr_q;
  assign rx_frame_error     = ferr_q;
  assign output_axis.tdata  = out_dat_q;
  assign output_axis.tvalid = out_vld_q;

endmodule

// File: tb/tb_axis_uart.sv
// Self-checking bench for axis_uart: loopback and bench-driven rxd frames
// against a frame-level model (10-bit frame words, byte queues, bit-period arithmetic).
module tb_axis_uart;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rxd_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic [15:0] prescale = 16'd1;
  logic        rxd;
  logic        txd, tx_busy, rx_busy, rx_overrun_error, rx_frame_error;

  axis_uart_if in_if ();
  axis_uart_if out_if ();

  assign rxd = loop_en ? txd : rxd_drv;

  axis_uart dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .input_axis       (in_if),
    .output_axis      (out_if),
    .rxd              (rxd),
    .txd              (txd),
    .tx_busy          (tx_busy),
    .rx_busy          (rx_busy),
    .rx_overrun_error (rx_overrun_error),
    .rx_frame_error   (rx_frame_error),
    .prescale         (prescale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] rx_log[$];
  int         rx_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_overrun_error === 1'b1) ovr_cnt++;
    if (rx_frame_error === 1'b1) ferr_cnt++;
    if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
      rx_log.push_back(out_if.tdata);
      rx_cyc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int eff(input logic [15:0] p);
    return (p == 16'd0) ? 1 : int'(p);
  endfunction

  function automatic logic fbit(input logic [7:0] b, input int i);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[i];
  endfunction

  task automatic start_tx(input logic [7:0] b, input bit keep, output int hs);
    int n;
    n = 0;
    in_if.tdata  = b;
    in_if.tvalid = 1'b1;
    while (in_if.tready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL tx_handshake_timeout: tready=%b want 1", in_if.tready);
    end
    @(negedge clk);
    hs = cyc;
    if (!keep) in_if.tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = f[i];
      repeat (8 * eff(prescale)) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset;
    logic [12:0] got;
    repeat (2) @(negedge clk);
    got = {txd, in_if.tready, tx_busy, out_if.tdata, out_if.tvalid, rx_busy};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got, 13'b1_0_0_00000000_0_0);
    end
    checks++;
    if ({rx_overrun_error, rx_frame_error} !== 2'b00) begin
      errors++;
      $display("FAIL reset_error_pulses: got %b want 00", {rx_overrun_error, rx_frame_error});
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready_before_edge: got %b want 0", in_if.tready);
    end
    @(negedge clk);
    checks++;
    if (in_if.tready !== 1'b1 || txd !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_after_edge: tready=%b txd=%b want 1 1", in_if.tready, txd);
    end
  endtask

  task automatic test_loopback(input logic [7:0] b, input logic [15:0] p);
    int hs, o0, f0, lat, bp;
    prescale = p;
    bp = 8 * eff(p);
    loop_en = 1'b1;
    out_if.tready = 1'b1;
    rx_log.delete();
    rx_cyc.delete();
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    start_tx(b, 1'b0, hs);
    checks++;
    if (tx_busy !== 1'b1 || in_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL lb_busy_start: tx_busy=%b tready=%b want 1 0", tx_busy, in_if.tready);
    end
    for (int k = 0; k < 10 * bp; k++) begin
      checks++;
      if (txd !== fbit(b, k / bp)) begin
        errors++;
        $display("FAIL lb_txd_bit%0d cycle %0d: got %b want %b", k / bp, k, txd, fbit(b, k / bp));
      end
      @(negedge clk);
    end
    checks++;
    if (tx_busy !== 1'b0 || in_if.tready !== 1'b1) begin
      errors++;
      $display("FAIL lb_end_of_frame: tx_busy=%b tready=%b want 0 1", tx_busy, in_if.tready);
    end
    wait_rx(1, 40 * bp);
    checks++;
    if (rx_log.size() != 1) begin
      errors++;
      $display("FAIL lb_rx_count: got %0d want 1", rx_log.size());
    end else begin
      lat = rx_cyc[0] - hs;
      checks++;
      if (rx_log[0] !== b) begin
        errors++;
        $display("FAIL lb_rx_data: got %h want %h", rx_log[0], b);
      end
      checks++;
      if (lat < 76 * eff(p) || lat > 76 * eff(p) + 4) begin
        errors++;
        $display("FAIL lb_rx_latency: got %0d want %0d..%0d", lat, 76 * eff(p), 76 * eff(p) + 4);
      end
    end
    checks++;
    if (ovr_cnt != o0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL lb_errors: overruns=%0d frame=%0d want 0 0", ovr_cnt - o0, ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back(input logic [15:0] p);
    int hs1, hs2, o0, f0;
    prescale = p;
    loop_en = 1'b1;
    out_if.tready = 1'b1;
    rx_log.delete();
    rx_cyc.delete();
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    start_tx(8'h00, 1'b1, hs1);
    in_if.tdata = 8'hFF;
    start_tx(8'hFF, 1'b0, hs2);
    checks++;
    if (hs2 - hs1 != 80 * eff(p) + 1) begin
      errors++;
      $display("FAIL b2b_spacing p=%0d: got %0d want %0d", p, hs2 - hs1, 80 * eff(p) + 1);
    end
    wait_rx(2, 200 * eff(p));
    checks++;
    if (rx_log.size() != 2) begin
      errors++;
      $display("FAIL b2b_rx_count: got %0d want 2", rx_log.size());
    end else begin
      checks++;
      if (rx_log[0] !== 8'h00 || rx_log[1] !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_rx_order: got %h %h want 00 ff", rx_log[0], rx_log[1]);
      end
    end
    checks++;
    if (ovr_cnt != o0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL b2b_errors: overruns=%0d frame=%0d want 0 0", ovr_cnt - o0, ferr_cnt - f0);
    end
    repeat (8 * eff(p) + 4) @(negedge clk);
  endtask

  task automatic test_overrun;
    logic [7:0] b1, b2;
    int o0, f0;
    loop_en = 1'b0;
    out_if.tready = 1'b0;
    prescale = 16'($urandom_range(1, 3));
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    drive_frame(b1, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== b1) begin
      errors++;
      $display("FAIL ovr_first_byte: vld=%b data=%h want 1 %h", out_if.tvalid, out_if.tdata, b1);
    end
    drive_frame(b2, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (ovr_cnt - o0 != 1) begin
      errors++;
      $display("FAIL ovr_pulse_count: got %0d want 1", ovr_cnt - o0);
    end
    checks++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== b2) begin
      errors++;
      $display("FAIL ovr_second_byte: vld=%b data=%h want 1 %h", out_if.tvalid, out_if.tdata, b2);
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL ovr_frame_err: got %0d want 0", ferr_cnt - f0);
    end
    out_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_consume: vld=%b want 0", out_if.tvalid);
    end
    out_if.tready = 1'b0;
  endtask

  task automatic test_frame_error;
    int o0, f0;
    loop_en = 1'b0;
    out_if.tready = 1'b0;
    prescale = 16'd2;
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    drive_frame(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL ferr_pulse_count: got %0d want 1", ferr_cnt - f0);
    end
    checks++;
    if (out_if.tvalid !== 1'b0 || ovr_cnt != o0) begin
      errors++;
      $display("FAIL ferr_no_output: vld=%b overruns=%0d want 0 0", out_if.tvalid, ovr_cnt - o0);
    end
  endtask

  task automatic test_break;
    logic [7:0] b;
    int f0;
    loop_en = 1'b0;
    out_if.tready = 1'b0;
    prescale = 16'd1;
    b = 8'($urandom);
    f0 = ferr_cnt;
    rxd_drv = 1'b0;
    repeat (320) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 != 1 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL break_hold: frame_errs=%0d rx_busy=%b want 1 0", ferr_cnt - f0, rx_busy);
    end
    rxd_drv = 1'b1;
    repeat (10) @(negedge clk);
    drive_frame(b, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== b) begin
      errors++;
      $display("FAIL break_rearm: vld=%b data=%h want 1 %h", out_if.tvalid, out_if.tdata, b);
    end
    out_if.tready = 1'b1;
    repeat (2) @(negedge clk);
    out_if.tready = 1'b0;
  endtask

  task automatic test_glitch;
    int o0, f0, p;
    bit seen_busy;
    loop_en = 1'b0;
    out_if.tready = 1'b0;
    p = $urandom_range(1, 4);
    prescale = 16'(p);
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    seen_busy = 1'b0;
    rxd_drv = 1'b0;
    for (int k = 0; k < 12 * p + 10; k++) begin
      if (k == 2 * p) rxd_drv = 1'b1;
      if (rx_busy === 1'b1) seen_busy = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_busy !== 1'b1 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: seen=%b final=%b want 1 0", seen_busy, rx_busy);
    end
    checks++;
    if (out_if.tvalid !== 1'b0 || ovr_cnt != o0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL glitch_no_output: vld=%b ovr=%0d ferr=%0d want 0 0 0",
               out_if.tvalid, ovr_cnt - o0, ferr_cnt - f0);
    end
  endtask

  task automatic test_reset_mid_tx;
    int hs;
    logic [7:0] b2;
    loop_en = 1'b1;
    out_if.tready = 1'b1;
    prescale = 16'd2;
    b2 = 8'($urandom);
    rx_log.delete();
    rx_cyc.delete();
    start_tx(8'h00, 1'b0, hs);
    repeat (40) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: txd=%b busy=%b want 0 1", txd, tx_busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || in_if.tready !== 1'b0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: txd=%b tready=%b busy=%b want 1 0 0", txd, in_if.tready, tx_busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_if.tready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_tready_release: got %b want 0", in_if.tready);
    end
    @(negedge clk);
    checks++;
    if (in_if.tready !== 1'b1 || out_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: tready=%b rx_vld=%b want 1 0", in_if.tready, out_if.tvalid);
    end
    start_tx(b2, 1'b0, hs);
    wait_rx(1, 400);
    repeat (20) @(negedge clk);
    checks++;
    if (rx_log.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_rx_count: got %0d want 1", rx_log.size());
    end else begin
      checks++;
      if (rx_log[0] !== b2) begin
        errors++;
        $display("FAIL rst_mid_rx_data: got %h want %h", rx_log[0], b2);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int hs, o0, f0, p;
    loop_en = 1'b1;
    out_if.tready = 1'b1;
    rx_log.delete();
    rx_cyc.delete();
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(0, 3);
      prescale = 16'(p);
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start_tx(b, 1'b0, hs);
      exp_q.push_back(b);
      wait_rx(exp_q.size(), 120 * eff(16'(p)));
      repeat (8 * eff(16'(p)) + 2) @(negedge clk);
    end
    checks++;
    if (rx_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_rx_count: got %0d want %0d", rx_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (rx_log[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_rx_byte%0d: got %h want %h", i, rx_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ovr_cnt != o0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL rand_errors: overruns=%0d frame=%0d want 0 0", ovr_cnt - o0, ferr_cnt - f0);
    end
  endtask

  initial begin
    in_if.tdata   = 8'h00;
    in_if.tvalid  = 1'b0;
    out_if.tready = 1'b0;
    test_reset();
    test_loopback(8'hA5, 16'd1);
    test_loopback(8'($urandom), 16'd3);
    test_back_to_back(16'd4);
    test_back_to_back(16'd0);
    test_overrun();
    test_frame_error();
    test_break();
    test_glitch();
    test_reset_mid_tx();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
